// File: rtl/alsu_cmd_issuer.sv
// alsu_cmd_issuer: FIFO-buffered ALSU command issuer with repeat expansion and a latency-matched tagged response strobe
module alsu_cmd_issuer #(
    parameter int DEPTH    = 4,
    parameter int TAG_W    = 4,
    parameter int ALSU_LAT = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [2:0]                 cmd_opcode,
    input  logic [2:0]                 cmd_A,
    input  logic [2:0]                 cmd_B,
    input  logic                       cmd_cin,
    input  logic                       cmd_serial_in,
    input  logic                       cmd_direction,
    input  logic                       cmd_red_op_A,
    input  logic                       cmd_red_op_B,
    input  logic                       cmd_bypass_A,
    input  logic                       cmd_bypass_B,
    input  logic [2:0]                 cmd_repeat,
    input  logic [TAG_W-1:0]           cmd_tag,
    output logic [2:0]                 opcode,
    output logic [2:0]                 A,
    output logic [2:0]                 B,
    output logic                       cin,
    output logic                       serial_in,
    output logic                       direction,
    output logic                       red_op_A,
    output logic                       red_op_B,
    output logic                       bypass_A,
    output logic                       bypass_B,
    output logic                       issue_valid,
    output logic                       rsp_valid,
    output logic [TAG_W-1:0]           rsp_tag,
    output logic                       rsp_last,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full
);
    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH+1);
    localparam int PIN_W = 16;
    localparam int W     = PIN_W + TAG_W + 3;

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             empty_q, empty_d, full_q, full_d;
    logic [PIN_W-1:0] pins_q, pins_d;
    logic             issue_q, issue_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [2:0]       rpt_q, rpt_d;
    logic [TAG_W+1:0] pipe_q [ALSU_LAT];
    logic [TAG_W+1:0] pipe_d [ALSU_LAT];
    logic             push, pop, hold;
    logic [W-1:0]     cmd_word, head;
    logic [2:0]       head_op, head_rpt;

    assign cmd_word = {cmd_repeat, cmd_tag, cmd_opcode, cmd_A, cmd_B, cmd_cin, cmd_serial_in,
                       cmd_direction, cmd_red_op_A, cmd_red_op_B, cmd_bypass_A, cmd_bypass_B};
    assign head     = mem_q[rd_ptr_q];
    assign head_op  = head[PIN_W-1 -: 3];
    assign head_rpt = head[W-1 -: 3];

    always_comb begin
        push     = cmd_valid && !full_q;
        hold     = (state_q == ACTIVE) && (rpt_q != 3'd0);
        pop      = !hold && !empty_q;
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        empty_d  = count_d == '0;
        full_d   = count_d == CW'(DEPTH);
        state_d  = (hold || pop) ? ACTIVE : IDLE;
        issue_d  = hold || pop;
        pins_d   = hold ? pins_q : pop ? head[PIN_W-1:0] : '0;
        tag_d    = hold ? tag_q : pop ? head[PIN_W +: TAG_W] : '0;
        // Repeat is only meaningful for the shift and rotate opcodes
        rpt_d    = hold ? rpt_q - 3'd1 :
                   (pop && (head_op == 3'd4 || head_op == 3'd5)) ? head_rpt : 3'd0;
        pipe_d[0] = {issue_q, tag_q, issue_q && (rpt_q == 3'd0)};
        for (int i = 1; i < ALSU_LAT; i++) pipe_d[i] = pipe_q[i-1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            pins_q   <= '0;
            issue_q  <= 1'b0;
            tag_q    <= '0;
            rpt_q    <= '0;
            for (int i = 0; i < ALSU_LAT; i++) pipe_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            pins_q   <= pins_d;
            issue_q  <= issue_d;
            tag_q    <= tag_d;
            rpt_q    <= rpt_d;
            pipe_q   <= pipe_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= cmd_word;
    end

    assign {opcode, A, B, cin, serial_in, direction, red_op_A, red_op_B, bypass_A, bypass_B} = pins_q;
    assign issue_valid = issue_q;
    assign rsp_valid   = pipe_q[ALSU_LAT-1][TAG_W+1];
    assign rsp_tag     = pipe_q[ALSU_LAT-1][TAG_W:1];
    assign rsp_last    = pipe_q[ALSU_LAT-1][0];
    assign cmd_ready   = !full_q;
    assign count       = count_q;
    assign empty       = empty_q;
    assign full        = full_q;
endmodule

// File: tb/tb_alsu_cmd_issuer.sv
// tb_alsu_cmd_issuer: directed self-checking bench for alsu_cmd_issuer
module tb_alsu_cmd_issuer;
    logic       clk = 1'b0, reset = 1'b1;
    logic       cmd_valid = 1'b0, cmd_ready;
    logic [2:0] cmd_opcode = '0, cmd_A = '0, cmd_B = '0, cmd_repeat = '0;
    logic       cmd_cin = 1'b0, cmd_serial_in = 1'b0, cmd_direction = 1'b0;
    logic       cmd_red_op_A = 1'b0, cmd_red_op_B = 1'b0, cmd_bypass_A = 1'b0, cmd_bypass_B = 1'b0;
    logic [3:0] cmd_tag = '0;
    logic [2:0] opcode, A, B;
    logic       cin, serial_in, direction, red_op_A, red_op_B, bypass_A, bypass_B;
    logic       issue_valid, rsp_valid, rsp_last, empty, full;
    logic [3:0] rsp_tag;
    logic [2:0] count;
    int         total = 0, passed = 0;

    alsu_cmd_issuer #(.DEPTH(4), .TAG_W(4), .ALSU_LAT(2)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_opcode(cmd_opcode), .cmd_A(cmd_A), .cmd_B(cmd_B), .cmd_cin(cmd_cin),
        .cmd_serial_in(cmd_serial_in), .cmd_direction(cmd_direction),
        .cmd_red_op_A(cmd_red_op_A), .cmd_red_op_B(cmd_red_op_B),
        .cmd_bypass_A(cmd_bypass_A), .cmd_bypass_B(cmd_bypass_B),
        .cmd_repeat(cmd_repeat), .cmd_tag(cmd_tag),
        .opcode(opcode), .A(A), .B(B), .cin(cin), .serial_in(serial_in), .direction(direction),
        .red_op_A(red_op_A), .red_op_B(red_op_B), .bypass_A(bypass_A), .bypass_B(bypass_B),
        .issue_valid(issue_valid), .rsp_valid(rsp_valid), .rsp_tag(rsp_tag), .rsp_last(rsp_last),
        .count(count), .empty(empty), .full(full)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string t, input logic [31:0] o, input logic [31:0] e);
        total++;
        assert (o === e) passed++;
        else $error("FAIL %s: got %0h expected %0h", t, o, e);
    endtask

    task automatic set_cmd(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b,
                           input logic dir, input logic sin, input logic [2:0] rep, input logic [3:0] tag);
        cmd_opcode = op; cmd_A = a; cmd_B = b; cmd_direction = dir; cmd_serial_in = sin;
        cmd_repeat = rep; cmd_tag = tag;
    endtask

    initial begin
        tick();
        tick();
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_ready", 32'(cmd_ready), 1);
        chk("rst_issue", 32'(issue_valid), 0);
        chk("rst_rsp", 32'({rsp_valid, rsp_tag, rsp_last}), 0);
        chk("rst_pins", 32'({opcode, A, B, direction, serial_in}), 0);
        reset = 1'b0;
        tick();

        // single command
        set_cmd(3'd0, 3'b011, 3'b110, 1'b0, 1'b0, 3'd0, 4'd5);
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        chk("t1_count", 32'(count), 1);
        chk("t1_nopin", 32'(issue_valid), 0);
        tick();
        chk("t1_issue", 32'(issue_valid), 1);
        chk("t1_pins", 32'({opcode, A, B}), 32'({3'd0, 3'b011, 3'b110}));
        chk("t1_empty", 32'(empty), 1);
        tick();
        chk("t1_issue_off", 32'(issue_valid), 0);
        chk("t1_rsp_early", 32'(rsp_valid), 0);
        tick();
        chk("t1_rsp", 32'({rsp_valid, rsp_tag, rsp_last}), 32'({1'b1, 4'd5, 1'b1}));
        tick();
        chk("t1_rsp_off", 32'(rsp_valid), 0);

        // back-to-back, tags 1..4
        for (int j = 1; j <= 7; j++) begin
            cmd_valid = (j <= 4);
            set_cmd(3'd3, 3'(j), 3'd1, 1'b0, 1'b0, 3'd0, 4'(j));
            tick();
            if (j >= 2 && j <= 5) begin
                chk("t2_issue", 32'(issue_valid), 1);
                chk("t2_A", 32'(A), 32'(j - 1));
            end
            if (j >= 6) chk("t2_issue_off", 32'(issue_valid), 0);
            if (j >= 4) chk("t2_rsp", 32'({rsp_valid, rsp_tag, rsp_last}), 32'({1'b1, 4'(j - 3), 1'b1}));
        end
        cmd_valid = 1'b0;
        tick();
        chk("t2_rsp_off", 32'(rsp_valid), 0);

        // shift with repeat 3
        set_cmd(3'd4, 3'd0, 3'd0, 1'b1, 1'b1, 3'd3, 4'd7);
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        for (int j = 1; j <= 7; j++) begin
            tick();
            chk("t3_issue", 32'(issue_valid), 32'(j <= 4));
            chk("t3_pins", 32'({opcode, direction, serial_in}), (j <= 4) ? 32'({3'd4, 1'b1, 1'b1}) : 0);
            chk("t3_rsp", 32'({rsp_valid, rsp_last}), 32'({j >= 3 && j <= 6, j == 6}));
            if (rsp_valid) chk("t3_tag", 32'(rsp_tag), 7);
        end

        // repeat ignored for opcode 1
        set_cmd(3'd1, 3'd2, 3'd3, 1'b0, 1'b0, 3'd7, 4'd9);
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        for (int j = 1; j <= 4; j++) begin
            tick();
            chk("t4_issue", 32'(issue_valid), 32'(j == 1));
            chk("t4_rsp", 32'({rsp_valid, rsp_tag, rsp_last}), (j == 3) ? 32'({1'b1, 4'd9, 1'b1}) : 0);
        end

        // backpressure behind a long-repeat head
        set_cmd(3'd5, 3'd1, 3'd0, 1'b0, 1'b0, 3'd7, 4'd0);
        cmd_valid = 1'b1;
        tick();
        for (int j = 1; j <= 15; j++) begin
            cmd_valid = (j <= 6);
            set_cmd(3'd2, 3'd1, 3'd1, 1'b0, 1'b0, 3'd0, 4'(j));
            tick();
            if (j >= 4 && j <= 6) begin
                chk("t5_count_full", 32'(count), 4);
                chk("t5_flags", 32'({full, cmd_ready}), 32'({1'b1, 1'b0}));
            end
            if (j >= 9 && j <= 12) chk("t5_drain", 32'(count), 32'(12 - j));
            if (j >= 11 && j <= 14) chk("t5_rsp", 32'({rsp_valid, rsp_tag, rsp_last}), 32'({1'b1, 4'(j - 10), 1'b1}));
        end
        chk("t5_end", 32'({rsp_valid, issue_valid, empty}), 32'({1'b0, 1'b0, 1'b1}));

        // reset during the second repeat cycle of a shift
        set_cmd(3'd4, 3'd0, 3'd0, 1'b1, 1'b1, 3'd3, 4'd3);
        cmd_valid = 1'b1;
        tick();
        set_cmd(3'd0, 3'd1, 3'd1, 1'b0, 1'b0, 3'd0, 4'd4);
        tick();
        cmd_valid = 1'b0;
        chk("t6_issue", 32'({issue_valid, opcode}), 32'({1'b1, 3'd4}));
        tick();
        chk("t6_count", 32'(count), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_pins", 32'({issue_valid, opcode, direction, serial_in}), 0);
        chk("t6_rsp", 32'(rsp_valid), 0);
        chk("t6_fifo", 32'({count, empty}), 32'({3'd0, 1'b1}));
        tick();
        chk("t6_flush", 32'({rsp_valid, issue_valid}), 0);
        set_cmd(3'd2, 3'd5, 3'd1, 1'b0, 1'b0, 3'd0, 4'd6);
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("t6_reissue", 32'({issue_valid, opcode, A}), 32'({1'b1, 3'd2, 3'd5}));
        tick();
        tick();
        chk("t6_rsp_after", 32'({rsp_valid, rsp_tag, rsp_last}), 32'({1'b1, 4'd6, 1'b1}));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/alsu_cmd_issuer.md
Name: alsu_cmd_issuer

Overview:
Upstream command stage for the ALSU. It buffers ALSU commands in a FIFO with a valid/ready handshake and drives the ALSU input pins from registers. It expands shift/rotate commands into repeated cycles, and drives an all-zero idle word when it has nothing to issue. It also produces tagged response strobes, delay-matched to the ALSU's two-cycle input-to-output latency, so a downstream checker or collector can sample `out` and `leds`.

Parameters:
DEPTH, 4, FIFO entries; power of two, at least 2.
TAG_W, 4, width of the command tag.
ALSU_LAT, 2, cycles from pins driven to ALSU `out` valid.

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  FIFO can accept; equals !full
cmd_opcode  in  3  ALSU opcode
cmd_A, cmd_B  in  3 each  operands (signed)
cmd_cin, cmd_serial_in, cmd_direction  in  1 each  ALSU control bits
cmd_red_op_A, cmd_red_op_B, cmd_bypass_A, cmd_bypass_B  in  1 each  ALSU control bits
cmd_repeat  in  3  extra issue cycles; honoured only for opcode 4 and 5
cmd_tag  in  TAG_W  user tag
opcode, A, B, cin, serial_in, direction, red_op_A, red_op_B, bypass_A, bypass_B  out  same widths  registered ALSU pin drive
issue_valid  out  1  pins currently carry a command
rsp_valid  out  1  ALSU `out` in this cycle belongs to an issued command cycle
rsp_tag  out  TAG_W  tag of that command
rsp_last  out  1  final cycle of that command
count  out  $clog2(DEPTH+1)  FIFO occupancy
empty, full  out  1 each  FIFO flags

Behaviour:
- Reset (synchronous, at posedge clk while reset=1):
  - FIFO pointers and count go to 0; empty=1, full=0, cmd_ready=1.
  - All pin-drive registers go to 0, and issue_valid=0.
  - The response pipeline is flushed, so rsp_valid=0, rsp_tag=0, rsp_last=0.
  - The FSM goes to IDLE and the repeat counter goes to 0.
  - Reset mid-operation aborts the current command and any in-flight responses. Flushed responses are never emitted.
- Push: occurs when cmd_valid && cmd_ready at posedge. Because cmd_ready=!full, there is no push when full. There is no FIFO bypass.
- FSM states are IDLE and ACTIVE.
  - IDLE, FIFO non-empty: pop the head, load the pin registers and rpt_cnt (set to cmd_repeat if opcode is 4 or 5, else 0), set issue_valid=1, go to ACTIVE.
  - IDLE, FIFO empty: drive the idle word (all pin fields 0), issue_valid=0.
  - ACTIVE, rpt_cnt>0: hold the pin registers, decrement rpt_cnt, keep issue_valid=1.
  - ACTIVE, rpt_cnt==0, FIFO non-empty: pop the next entry back-to-back (no bubble) and load it as in IDLE.
  - ACTIVE, rpt_cnt==0, FIFO empty: load the idle word, issue_valid=0, go to IDLE.
- Simultaneous push and pop: count is unchanged. A push into an empty FIFO becomes poppable on the following cycle.
- Latency:
  - A command accepted at edge N appears on the pins after edge N+1.
  - Its first rsp_valid is after edge N+1+ALSU_LAT.
  - A command with effective repeat R occupies the pins for R+1 consecutive cycles.
- Response pipeline: {issue_valid, tag, last} is delayed by ALSU_LAT register stages.
  - last=1 on the cycle where rpt_cnt==0.
  - rsp_valid pulses once per issued cycle; rsp_last marks the final one.
- The ALSU shift register is not preserved across idle gaps, because the idle word produces out=0. Chained shifts must use cmd_repeat.
- Full back-to-back throughput is 1 command per cycle for commands with repeat 0.
- count, empty and full are registered and exact.
- Pointers wrap modulo DEPTH.
- The tag passes through unmodified.

Test Plan:
1. Single command: push opcode=0, A=3'b011, B=3'b110, tag=5 at edge N. Required: pins show the command after N+1 with issue_valid=1 for 1 cycle. After N+3, rsp_valid=1, rsp_tag=5, rsp_last=1, and ALSU out=6'b000010.
2. Back-to-back: push 4 commands on consecutive cycles (tags 1..4, opcode 3). Required: 4 consecutive issue_valid cycles with no bubble, and rsp_tag sequence 1,2,3,4, each with rsp_last=1.
3. Repeat on shift: opcode=4, direction=1, serial_in=1, repeat=3. Required: pins held 4 cycles; rsp_valid for 4 cycles with rsp_last only on the 4th; ALSU out=000001, 000011, 000111, 001111.
4. Repeat ignored: opcode=1 with repeat=7. Required: exactly 1 issue cycle, rsp_last=1.
5. Backpressure: hold the head with repeat=7 and push until full. Required: count=DEPTH, full=1, cmd_ready=0, no extra entries accepted. Count then drops by 1 per pop, and all tags are issued in order.
6. Reset mid-operation: assert reset for 1 cycle during the 2nd repeat of a shift. Required: the next cycle shows pins=0, issue_valid=0, rsp_valid=0, count=0, empty=1. A command pushed afterward issues normally.
